mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares the single main_memory port
//  between NUM_REQ cache controllers. Holds one outstanding transaction at a
//  time, issues it as a one-cycle mem_req_valid pulse, tracks the memory's
//  ready/response handshake, and routes the read line back to the winner.
//  Sits between the per-core caches and main_memory in the top module.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2); ID width = $clog2(NUM_REQ)
//  Widths: LA = `ADDR_BITS-`OFFSET_BITS (line address), CL = `CACHELINE_BITS
// PORTS
//  clk             in   1          clock
//  reset_n         in   1          asynchronous, active-low reset
//  core_req_valid  in   NUM_REQ    per-requester request valid
//  core_req_rw     in   NUM_REQ    0 read, 1 write, per requester
//  core_req_addr   in   NUM_REQ*LA packed line addresses, [i*LA +: LA]
//  core_req_data   in   NUM_REQ*CL packed write lines, [i*CL +: CL]
//  core_req_ready  out  NUM_REQ    one-hot accept pulse to winner
//  core_resp_valid out  NUM_REQ    one-hot read-data-valid to winner
//  core_resp_data  out  CL         read line, broadcast to all requesters
//  mem_req_valid   out  1          request to main memory
//  mem_req_rw      out  1          0 read, 1 write
//  mem_req_addr    out  LA         line address
//  mem_req_data    out  CL         write line
//  mem_req_ready   in   1          memory can accept
//  mem_resp_valid  in   1          memory read-data pulse
//  mem_resp_data   in   CL         memory read line
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, grant=0, all outputs 0 (mem_req_* and
//   latched rw/addr/data cleared). Reset mid-transaction aborts to IDLE; the
//   lost transaction is not replayed and no response is routed.
//  States: IDLE -> ISSUE -> BUSY -> DRAIN -> IDLE.
//  IDLE: if any core_req_valid && mem_req_ready, pick winner: first set bit
//   scanning rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 -> 0. At clk edge:
//   latch winner's rw/addr/data into mem_req_*, grant=winner,
//   rr_ptr=(winner+1)%NUM_REQ, go ISSUE.
//  ISSUE (exactly 1 cycle): mem_req_valid=1, core_req_ready[grant]=1 (both
//   registered, so the pulses align). Go BUSY. Requester holds its valid/rw/
//   addr/data until it sees core_req_ready; it may drop valid earlier without
//   penalty (no grant given). Valid seen with core_req_ready = new request.
//  BUSY: wait for mem_req_ready==0 (memory acknowledged); go DRAIN.
//  DRAIN: read: core_resp_valid[grant]=mem_resp_valid (combinational,
//   0-cycle latency), core_resp_data=mem_resp_data at all times. On
//   mem_req_ready==1 go IDLE; arbitration can fire in that same IDLE cycle.
//   Write: no response; completes on mem_req_ready==1.
//  mem_resp_valid outside DRAIN or during a write is ignored (never routed).
//  At most one transaction outstanding; min spacing IDLE->ISSUE is 1 cycle.
//  Starvation-free: with all requesters busy, each granted once per NUM_REQ
//   grants.
// CONFIGURATION
//  MEM_ARB_WRITE_PRIO_EN defined: in IDLE, if any valid requester has rw=1,
//   candidates restricted to writers (round-robin among them, same rr_ptr);
//   reads only win when no write is pending (writebacks drain first).
//  Undefined: pure round-robin, rw ignored for arbitration.
// TESTING
//  1 Single read: core1 read addr 0x10, mem preloaded 0xA5.. -> one
//    mem_req_valid pulse with addr 0x10, rw 0; core_req_ready[1] same cycle;
//    core_resp_valid=4'b0010 once with data 0xA5..; nothing else asserted.
//  2 Write then read-back: core0 write 0x20 <- 0xDEAD, then core2 read 0x20
//    -> core_resp_valid[2] with 0xDEAD; write yields no core_resp_valid.
//  3 All four request reads at once after reset -> grant order 0,1,2,3,
//    each completes before next mem_req_valid; re-requests continue 0,1,..
//  4 Wrap: only core3 and core0 valid with rr_ptr=3 -> grants 3 then 0.
//  5 Write prio (MEM_ARB_WRITE_PRIO_EN): core0 read + core2 write together
//    -> core2 granted first; without macro -> core0 first.
//  6 Reset asserted in DRAIN of a read -> all outputs 0 next sample, no
//    core_resp_valid; after memory ready returns, new request served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the per-core cache controllers and main memory.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LA      = 12,
  parameter int CL      = 32
);
  logic [NUM_REQ-1:0]    core_req_valid;
  logic [NUM_REQ-1:0]    core_req_rw;
  logic [NUM_REQ*LA-1:0] core_req_addr;
  logic [NUM_REQ*CL-1:0] core_req_data;
  logic [NUM_REQ-1:0]    core_req_ready;
  logic [NUM_REQ-1:0]    core_resp_valid;
  logic [CL-1:0]         core_resp_data;
  logic                  mem_req_valid;
  logic                  mem_req_rw;
  logic [LA-1:0]         mem_req_addr;
  logic [CL-1:0]         mem_req_data;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [CL-1:0]         mem_resp_data;

  modport slave (
    input  core_req_valid, core_req_rw, core_req_addr, core_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output core_req_ready, core_resp_valid, core_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  modport master (
    output core_req_valid, core_req_rw, core_req_addr, core_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  core_req_ready, core_resp_valid, core_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port among NUM_REQ caches, one transaction at a time.
// Optional MEM_ARB_WRITE_PRIO_EN: pending writers win over readers so writebacks drain first.
`ifndef ADDR_BITS
`define ADDR_BITS 16
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 4
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 32
`endif

module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LA      = `ADDR_BITS - `OFFSET_BITS,
  parameter int CL      = `CACHELINE_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic               mem_req_rw_q, mem_req_rw_d;
  logic [LA-1:0]      mem_req_addr_q, mem_req_addr_d;
  logic [CL-1:0]      mem_req_data_q, mem_req_data_d;
  logic [NUM_REQ-1:0] core_req_ready_q, core_req_ready_d;

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IDW-1:0]     winner;
  int                 idx;

  // Scan candidates starting at rr_ptr, wrapping, and take the first one found.
  always_comb begin
    cand = bus.core_req_valid;
`ifdef MEM_ARB_WRITE_PRIO_EN
    if (|(bus.core_req_valid & bus.core_req_rw)) cand = bus.core_req_valid & bus.core_req_rw;
`endif
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    mem_req_valid_d  = 1'b0;
    core_req_ready_d = '0;
    mem_req_rw_d     = mem_req_rw_q;
    mem_req_addr_d   = mem_req_addr_q;
    mem_req_data_d   = mem_req_data_q;
    case (state_q)
      IDLE: begin
        if (found && bus.mem_req_ready) begin
          state_d                  = ISSUE;
          grant_d                  = winner;
          rr_ptr_d                 = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          mem_req_valid_d          = 1'b1;
          core_req_ready_d[winner] = 1'b1;
          mem_req_rw_d             = bus.core_req_rw[winner];
          mem_req_addr_d           = bus.core_req_addr[int'(winner)*LA +: LA];
          mem_req_data_d           = bus.core_req_data[int'(winner)*CL +: CL];
        end
      end
      ISSUE:   state_d = BUSY;
      BUSY:    if (!bus.mem_req_ready) state_d = DRAIN;
      DRAIN:   if (bus.mem_req_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_rw_q     <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_data_q   <= '0;
      core_req_ready_q <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_rw_q     <= mem_req_rw_d;
      mem_req_addr_q   <= mem_req_addr_d;
      mem_req_data_q   <= mem_req_data_d;
      core_req_ready_q <= core_req_ready_d;
    end
  end

  // Read data is routed with zero latency, only while draining a read.
  always_comb begin
    bus.core_resp_valid = '0;
    if (state_q == DRAIN && !mem_req_rw_q && bus.mem_resp_valid)
      bus.core_resp_valid[grant_q] = 1'b1;
  end

  assign bus.core_resp_data = bus.mem_resp_data;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_req_rw     = mem_req_rw_q;
  assign bus.mem_req_addr   = mem_req_addr_q;
  assign bus.mem_req_data   = mem_req_data_q;
  assign bus.core_req_ready = core_req_ready_q;
endmodule
